// File: rtl/cix32_pipe_ctrl.sv
// CIX-32 pipeline control sequencer: turns hazard, LSU, redirect and multi-cycle
// execute events into per-stage stall/flush/bubble controls.
module cix32_pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MC_CNT_W     = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_use_hazard,
    input  logic                mem_busy,
    input  logic                mc_start,
    input  logic [MC_CNT_W-1:0] mc_cycles,
    input  logic                redirect_req,
    input  logic [31:0]         redirect_pc,
    output logic                stall_fetch,
    output logic                stall_decode,
    output logic                stall_execute,
    output logic                stall_memory,
    output logic                flush_fetch,
    output logic                flush_decode,
    output logic                bubble_execute,
    output logic                bubble_memory,
    output logic                fetch_redirect_valid,
    output logic [31:0]         fetch_redirect_pc,
    output logic                ctrl_busy,
    output logic [1:0]          ctrl_state
);

    localparam int FCNT_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MC    = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              state;
    logic [MC_CNT_W-1:0] mcnt;
    logic [FCNT_W-1:0]   fcnt;

    logic run_accept;
    logic take_redirect;
    logic take_mc;

    // Requests are only accepted in RUN on a cycle the LSU is not holding the pipe.
    assign run_accept    = (state == ST_RUN) && !mem_busy;
    assign take_redirect = run_accept && redirect_req;
    assign take_mc       = run_accept && !redirect_req && mc_start && (mc_cycles >= MC_CNT_W'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            mcnt  <= '0;
            fcnt  <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (take_redirect) begin
                        if (FLUSH_CYCLES > 0) begin
                            state <= ST_FLUSH;
                            fcnt  <= FCNT_W'(FLUSH_CYCLES);
                        end
                    end else if (take_mc) begin
                        state <= ST_MC;
                        mcnt  <= mc_cycles - MC_CNT_W'(1);
                    end
                end
                ST_MC: begin
                    if (!mem_busy) begin
                        if (mcnt <= MC_CNT_W'(1)) begin
                            state <= ST_RUN;
                            mcnt  <= '0;
                        end else begin
                            mcnt <= mcnt - MC_CNT_W'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    // The flush window is time-based, so it runs down through LSU stalls too.
                    if (fcnt <= FCNT_W'(1)) begin
                        state <= ST_RUN;
                        fcnt  <= '0;
                    end else begin
                        fcnt <= fcnt - FCNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_RUN;
                    mcnt  <= '0;
                    fcnt  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_fetch          = 1'b0;
        stall_decode         = 1'b0;
        stall_execute        = 1'b0;
        stall_memory         = 1'b0;
        flush_fetch          = 1'b0;
        flush_decode         = 1'b0;
        bubble_execute       = 1'b0;
        bubble_memory        = 1'b0;
        fetch_redirect_valid = 1'b0;

        case (state)
            ST_MC: begin
                stall_fetch   = 1'b1;
                stall_decode  = 1'b1;
                stall_execute = 1'b1;
                bubble_memory = !mem_busy;
            end
            ST_FLUSH: begin
                flush_fetch = 1'b1;
            end
            default: begin
                if (!mem_busy) begin
                    if (redirect_req) begin
                        fetch_redirect_valid = 1'b1;
                        flush_fetch          = 1'b1;
                        flush_decode         = 1'b1;
                        bubble_execute       = 1'b1;
                    end else if (!mc_start && load_use_hazard) begin
                        stall_fetch    = 1'b1;
                        stall_decode   = 1'b1;
                        bubble_execute = 1'b1;
                    end
                end
            end
        endcase

        // An LSU stall freezes every stage and overrides any bubble insertion.
        if (mem_busy) begin
            stall_fetch    = 1'b1;
            stall_decode   = 1'b1;
            stall_execute  = 1'b1;
            stall_memory   = 1'b1;
            bubble_execute = 1'b0;
            bubble_memory  = 1'b0;
        end
    end

    assign fetch_redirect_pc = redirect_pc;
    assign ctrl_busy         = (state == ST_MC) || (state == ST_FLUSH);
    assign ctrl_state        = state;

endmodule

// File: tb/tb_cix32_pipe_ctrl.sv
// Directed self-checking bench for cix32_pipe_ctrl (FLUSH_CYCLES = 2, MC_CNT_W = 6).
module tb_cix32_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_use_hazard;
    logic        mem_busy;
    logic        mc_start;
    logic [5:0]  mc_cycles;
    logic        redirect_req;
    logic [31:0] redirect_pc;
    logic        stall_fetch, stall_decode, stall_execute, stall_memory;
    logic        flush_fetch, flush_decode, bubble_execute, bubble_memory;
    logic        fetch_redirect_valid;
    logic [31:0] fetch_redirect_pc;
    logic        ctrl_busy;
    logic [1:0]  ctrl_state;

    int n_checks = 0;
    int n_fail   = 0;

    cix32_pipe_ctrl #(.FLUSH_CYCLES(2), .MC_CNT_W(6)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .load_use_hazard      (load_use_hazard),
        .mem_busy             (mem_busy),
        .mc_start             (mc_start),
        .mc_cycles            (mc_cycles),
        .redirect_req         (redirect_req),
        .redirect_pc          (redirect_pc),
        .stall_fetch          (stall_fetch),
        .stall_decode         (stall_decode),
        .stall_execute        (stall_execute),
        .stall_memory         (stall_memory),
        .flush_fetch          (flush_fetch),
        .flush_decode         (flush_decode),
        .bubble_execute       (bubble_execute),
        .bubble_memory        (bubble_memory),
        .fetch_redirect_valid (fetch_redirect_valid),
        .fetch_redirect_pc    (fetch_redirect_pc),
        .ctrl_busy            (ctrl_busy),
        .ctrl_state           (ctrl_state)
    );

    always #5 clk = ~clk;

    // Output bundle: {stall f,d,e,m, flush f,d, bubble e,m, redirect_valid, busy, state}
    logic [11:0] outs;
    assign outs = {stall_fetch, stall_decode, stall_execute, stall_memory,
                   flush_fetch, flush_decode, bubble_execute, bubble_memory,
                   fetch_redirect_valid, ctrl_busy, ctrl_state};

    function automatic logic [11:0] ev(input logic [3:0] stl, input logic [1:0] fl,
                                       input logic [1:0] bb, input logic rv,
                                       input logic [1:0] st);
        return {stl, fl, bb, rv, (st != 2'd0), st};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic lu, input logic mb, input logic mcs,
                         input logic [5:0] mcc, input logic rr, input logic [31:0] pc);
        load_use_hazard = lu;
        mem_busy        = mb;
        mc_start        = mcs;
        mc_cycles       = mcc;
        redirect_req    = rr;
        redirect_pc     = pc;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    localparam logic [11:0] IDLE = 12'h000;

    logic [4:0] busy_pat;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 6'd0, 0, 32'h0);

        // Reset and idle
        tick; #1;
        chk("reset_outs", 32'(outs), 32'(IDLE));
        rst_n = 1'b1;
        tick; #1;
        chk("idle_outs", 32'(outs), 32'(IDLE));

        // Multi-cycle op of 4: start cycle unstalled, then 3 MC cycles
        drive(0, 0, 1, 6'd4, 0, 32'h0); #1;
        chk("mc4_start", 32'(outs), 32'(IDLE));
        for (int i = 0; i < 3; i++) begin
            tick; drive(0, 0, 0, 6'd0, 0, 32'h0); #1;
            chk($sformatf("mc4_cyc%0d", i), 32'(outs), 32'(ev(4'b1110, 2'b00, 2'b01, 0, 2'd1)));
        end
        tick; #1;
        chk("mc4_done", 32'(outs), 32'(IDLE));

        // Multi-cycle op of 4 with two LSU-busy cycles: 5 MC cycles
        busy_pat = 5'b00110;
        drive(0, 0, 1, 6'd4, 0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick; drive(0, busy_pat[i], 0, 6'd0, 0, 32'h0); #1;
            if (busy_pat[i])
                chk($sformatf("mcb_cyc%0d", i), 32'(outs), 32'(ev(4'b1111, 2'b00, 2'b00, 0, 2'd1)));
            else
                chk($sformatf("mcb_cyc%0d", i), 32'(outs), 32'(ev(4'b1110, 2'b00, 2'b01, 0, 2'd1)));
        end
        tick; #1;
        chk("mcb_done", 32'(outs), 32'(IDLE));

        // Single-cycle op (mc_cycles = 1) causes no state change
        drive(0, 0, 1, 6'd1, 0, 32'h0); #1;
        chk("mc1_start", 32'(outs), 32'(IDLE));
        tick; drive(0, 0, 0, 6'd0, 0, 32'h0); #1;
        chk("mc1_after", 32'(outs), 32'(IDLE));

        // Redirect: accept cycle then 2 flush cycles
        drive(0, 0, 0, 6'd0, 1, 32'h0000_1040); #1;
        chk("redir_accept", 32'(outs), 32'(ev(4'b0000, 2'b11, 2'b10, 1, 2'd0)));
        chk("redir_pc", fetch_redirect_pc, 32'h0000_1040);
        tick; drive(0, 0, 0, 6'd0, 0, 32'h0); #1;
        chk("redir_flush1", 32'(outs), 32'(ev(4'b0000, 2'b10, 2'b00, 0, 2'd2)));
        tick; #1;
        chk("redir_flush2", 32'(outs), 32'(ev(4'b0000, 2'b10, 2'b00, 0, 2'd2)));
        tick; #1;
        chk("redir_done", 32'(outs), 32'(IDLE));

        // Redirect held through 2 mem_busy cycles; single strobe on the third
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0, 6'd0, 1, 32'h0000_2000); #1;
            chk($sformatf("rbusy_hold%0d", i), 32'(outs), 32'(ev(4'b1111, 2'b00, 2'b00, 0, 2'd0)));
            tick;
        end
        drive(0, 0, 0, 6'd0, 1, 32'h0000_2000); #1;
        chk("rbusy_accept", 32'(outs), 32'(ev(4'b0000, 2'b11, 2'b10, 1, 2'd0)));
        tick; drive(0, 0, 0, 6'd0, 1, 32'h0000_2000); #1;
        chk("rbusy_no2nd", 32'(outs), 32'(ev(4'b0000, 2'b10, 2'b00, 0, 2'd2)));
        // Flush window keeps counting through an LSU stall
        tick; drive(0, 1, 0, 6'd0, 0, 32'h0); #1;
        chk("rbusy_flushmb", 32'(outs), 32'(ev(4'b1111, 2'b10, 2'b00, 0, 2'd2)));
        tick; drive(0, 0, 0, 6'd0, 0, 32'h0); #1;
        chk("rbusy_done", 32'(outs), 32'(IDLE));

        // Simultaneous redirect + mc_start + load_use: redirect wins
        drive(1, 0, 1, 6'd5, 1, 32'h0000_3000); #1;
        chk("sim_accept", 32'(outs), 32'(ev(4'b0000, 2'b11, 2'b10, 1, 2'd0)));
        tick; drive(0, 0, 0, 6'd0, 0, 32'h0); #1;
        chk("sim_flush1", 32'(outs), 32'(ev(4'b0000, 2'b10, 2'b00, 0, 2'd2)));
        tick; #1;
        chk("sim_flush2", 32'(outs), 32'(ev(4'b0000, 2'b10, 2'b00, 0, 2'd2)));
        tick; drive(1, 0, 0, 6'd0, 0, 32'h0); #1;
        chk("loaduse", 32'(outs), 32'(ev(4'b1100, 2'b00, 2'b10, 0, 2'd0)));
        tick; drive(0, 0, 0, 6'd0, 0, 32'h0); #1;
        chk("loaduse_done", 32'(outs), 32'(IDLE));

        // Load-use during mem_busy gives only the LSU stall
        drive(1, 1, 0, 6'd0, 0, 32'h0); #1;
        chk("loaduse_mb", 32'(outs), 32'(ev(4'b1111, 2'b00, 2'b00, 0, 2'd0)));
        tick; drive(0, 0, 0, 6'd0, 0, 32'h0); #1;

        // Reset asserted mid-MC, then a fresh op of 3
        drive(0, 0, 1, 6'd4, 0, 32'h0);
        tick; drive(0, 0, 0, 6'd0, 0, 32'h0); #1;
        chk("rmc_in_mc", 32'(outs), 32'(ev(4'b1110, 2'b00, 2'b01, 0, 2'd1)));
        rst_n = 1'b0; #1;
        chk("rmc_reset", 32'(outs), 32'(IDLE));
        tick; rst_n = 1'b1; #1;
        chk("rmc_release", 32'(outs), 32'(IDLE));
        drive(0, 0, 1, 6'd3, 0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick; drive(0, 0, 0, 6'd0, 0, 32'h0); #1;
            chk($sformatf("rmc_fresh%0d", i), 32'(outs), 32'(ev(4'b1110, 2'b00, 2'b01, 0, 2'd1)));
        end
        tick; #1;
        chk("rmc_done", 32'(outs), 32'(IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cix32_pipe_ctrl.md
# cix32_pipe_ctrl

Pipeline control sequencer for the CIX-32 in-order pipeline. It sits between the hazard unit, the LSU and the execute stage, and turns their raw events into per-stage stall, flush and bubble controls:
- load-use hazard
- LSU busy
- taken branch/jump redirect
- multi-cycle execute ops (MUL/DIV/string)

It owns the execute-occupancy counter for multi-cycle ops and the post-redirect front-end flush window, so the hazard unit stays purely combinational.

## Interface
- FLUSH_CYCLES, 2: cycles after a redirect during which fetch output is discarded (0 = no FLUSH state).
- MC_CNT_W, 6: width of multi-cycle length field and internal counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- load_use_hazard  in  1  hazard unit: decode needs a result still loading in execute.
- mem_busy  in  1  LSU cannot complete the memory-stage access this cycle.
- mc_start  in  1  execute stage holds a multi-cycle op; held until accepted.
- mc_cycles  in  MC_CNT_W  total execute cycles of that op.
- redirect_req  in  1  taken branch/jump resolved in execute; held until accepted.
- redirect_pc  in  32  target address.
- stall_fetch, stall_decode, stall_execute, stall_memory  out  1  hold the stage register.
- flush_fetch, flush_decode  out  1  invalidate the stage register contents.
- bubble_execute, bubble_memory  out  1  load an invalid slot into that stage.
- fetch_redirect_valid  out  1  one-cycle redirect strobe to fetch.
- fetch_redirect_pc  out  32  redirect target (= redirect_pc).
- ctrl_busy  out  1  state != RUN.
- ctrl_state  out  2  RUN=0, MC=1, FLUSH=2 (3 unused; decodes as RUN).

## Operation
- States are registered; all outputs are combinational from state, counter and current inputs.
- `mem_busy`, any state:
  - All four stall_* = 1; bubble_* = 0.
  - Redirect and mc_start are not accepted.
  - Load-use produces no bubble.
- RUN, with mem_busy = 0. Priority is redirect > mc_start > load_use.
  - redirect_req: accepted.
    - fetch_redirect_valid = 1, flush_fetch = 1, flush_decode = 1, bubble_execute = 1.
    - Go to FLUSH with fcnt = FLUSH_CYCLES. If FLUSH_CYCLES = 0, stay in RUN.
    - mc_start and load_use are ignored that cycle.
  - mc_start with mc_cycles >= 2:
    - Go to MC with mcnt = mc_cycles - 1.
    - No stall in the start cycle.
  - mc_start with mc_cycles 0 or 1: single-cycle op; no state change.
  - load_use_hazard: stall_fetch = stall_decode = 1 and bubble_execute = 1 in that cycle only. The hazard unit re-asserts as needed.
- MC:
  - stall_fetch = stall_decode = stall_execute = 1.
  - bubble_memory = !mem_busy.
  - mcnt decrements only on cycles with mem_busy = 0. At mcnt == 1 with mem_busy = 0, return to RUN.
  - redirect_req, mc_start and load_use_hazard are ignored.
- FLUSH:
  - flush_fetch = 1 every cycle.
  - fcnt decrements every cycle, mem_busy included. At fcnt == 1, return to RUN.
  - redirect_req, mc_start and load_use_hazard are ignored; decode and execute hold only bubbles.
- fetch_redirect_pc = redirect_pc at all times; it is meaningful only while fetch_redirect_valid = 1.
- Arithmetic: counters are MC_CNT_W bits (fcnt sized for FLUSH_CYCLES), unsigned, and never wrap. Decrement happens only while in the owning state.

## Timing
- Reset (async assert, sync release): state = RUN, mcnt = fcnt = 0. With idle inputs, every output is 0.
- Reset asserted mid-MC or mid-FLUSH: immediate return to RUN; outputs drop to 0 in the same cycle.
- Redirect latency:
  - fetch_redirect_valid is asserted in the accept cycle, 0 cycles after the request.
  - Fetch sees the new PC on the next edge.
  - The front end discards FLUSH_CYCLES further cycles.
- Multi-cycle op of N >= 2 cycles, no mem_busy:
  - Execute is occupied exactly N cycles (start cycle plus N - 1 MC cycles).
  - Each mem_busy cycle extends this by one.
- Requesters must hold redirect_req/mc_start stable until a cycle with state = RUN and mem_busy = 0.

## Test plan
- Reset and idle: rst_n low mid-run, then released with all inputs 0 → every output 0, ctrl_state = 0.
- Multi-cycle op: mc_start = 1, mc_cycles = 4 in RUN → stall_execute = 1 for exactly 3 cycles, then RUN. Repeat with mem_busy = 1 for 2 of those cycles → 5 stall cycles, bubble_memory = 0 on the busy cycles.
- Redirect: redirect_req = 1, redirect_pc = 0x0000_1040, FLUSH_CYCLES = 2:
  - Accept cycle: fetch_redirect_valid = 1, pc = 0x1040, flush_fetch = flush_decode = bubble_execute = 1.
  - Then flush_fetch = 1 for 2 cycles, then RUN.
- Redirect during mem_busy: redirect_req held for 3 cycles with mem_busy = 1 for the first 2 → no strobe until the 3rd cycle; exactly one strobe.
- Simultaneous events: redirect_req + mc_start (mc_cycles = 5) + load_use_hazard in RUN → redirect wins, state goes to FLUSH, no MC entry. Then load_use_hazard alone → one cycle of stall_fetch = stall_decode = bubble_execute = 1.
- Reset mid-operation: rst_n pulsed low during MC with mcnt = 3 → ctrl_state = 0 and stall_execute = 0 immediately; next mc_start behaves as fresh.
